// File: rtl/uart_word_pkg.sv
// Shared types and frame constants for the UART word-query block.
package uart_word_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
module uart_byte_rx
    import uart_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic                      frame_start,
    output logic [UART_DATA_BITS-1:0] byte_out,
    output logic                      byte_valid,
    output logic                      stop_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID    = CW'(CLKS_PER_BIT / 2);
    // The detect cycle is already the first cycle of the start bit.
    localparam logic [CW-1:0] FIRST  = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    STOP_IDX = 4'(UART_FRAME_BITS - 1);

    logic                      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic                      armed_q, armed_d, active_q, active_d;
    logic [CW-1:0]             arm_cnt_q, arm_cnt_d, tmr_q, tmr_d;
    logic [3:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      valid_q, valid_d, err_q, err_d;

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        armed_d   = armed_q;
        arm_cnt_d = arm_cnt_q;
        active_d  = active_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        frame_start = armed_q && !active_q && prev_q && !sync2_q;

        // Line must sit high for a full bit before the first start edge counts.
        if (!armed_q) begin
            if (!sync2_q)
                arm_cnt_d = '0;
            else if (arm_cnt_q == BIT_TC)
                armed_d = 1'b1;
            else
                arm_cnt_d = arm_cnt_q + CW'(1);
        end

        if (frame_start) begin
            active_d = 1'b1;
            tmr_d    = FIRST;
            idx_d    = '0;
        end else if (active_q) begin
            if (tmr_q == '0) begin
                tmr_d = BIT_TC;
                idx_d = idx_q + 4'd1;
            end else begin
                tmr_d = tmr_q - CW'(1);
            end
            if (tmr_q == MID) begin
                if (idx_q == '0) begin
                    if (sync2_q)
                        active_d = 1'b0;
                end else if (idx_q == STOP_IDX) begin
                    active_d = 1'b0;
                    valid_d  = sync2_q;
                    err_d    = !sync2_q;
                end else begin
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            active_q  <= 1'b0;
            tmr_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            active_q  <= active_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign byte_out   = shift_q;
    assign byte_valid = valid_q;
    assign stop_err   = err_q;
endmodule

// File: rtl/uart_word_query.sv
// Sends an address over UART, then collects a fixed-length response word.
//   state | meaning
//   IDLE  | waiting for start
//   SEND  | shifting address frames out on tx
//   RECV  | assembling response bytes, watching for silence / bad stop
//   DONE  | one cycle: data updated, data_valid high
module uart_word_query
    import uart_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_BYTES   = 2,
    parameter int DATA_BYTES   = 4,
    parameter int MSB_FIRST    = 0,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic                    rx,
    output logic                    tx,
    output logic                    busy,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    data_valid,
    output logic                    timeout,
    output logic                    frame_err
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int SW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    STOP_IDX = 4'(UART_FRAME_BITS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] shift_q, shift_d, shift_nx;
    logic [8:0]    frame_q, frame_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_q, bit_d, left_q, left_d, cnt_q, cnt_d;
    logic [DW-1:0] asm_q, asm_d, asm_nx, data_q, data_d;
    logic [SW-1:0] sil_q, sil_d;
    logic          tx_q, tx_d, dv_q, dv_d, to_q, to_d, fe_q, fe_d;

    logic       rx_start, rx_valid, rx_err;
    logic [7:0] rx_byte;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .frame_start(rx_start),
        .byte_out   (rx_byte),
        .byte_valid (rx_valid),
        .stop_err   (rx_err)
    );

    function automatic logic [7:0] lead_byte(input logic [AW-1:0] v);
        return (MSB_FIRST != 0) ? v[AW-1 -: 8] : v[7:0];
    endfunction

    assign shift_nx = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
    assign asm_nx   = (MSB_FIRST != 0) ? ((asm_q << 8) | DW'(rx_byte))
                                       : ((asm_q >> 8) | (DW'(rx_byte) << (DW - 8)));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        frame_d = frame_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        data_d  = data_q;
        sil_d   = sil_q;
        tx_d    = tx_q;
        dv_d    = 1'b0;
        to_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                shift_d = addr;
                frame_d = {1'b1, lead_byte(addr)};
                tx_d    = 1'b0;
                tmr_d   = BIT_TC;
                bit_d   = '0;
                left_d  = 4'(ADDR_BYTES - 1);
            end
            SEND: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - CW'(1);
                end else begin
                    tmr_d = BIT_TC;
                    if (bit_q != STOP_IDX) begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = frame_q[0];
                        frame_d = {1'b0, frame_q[8:1]};
                    end else if (left_q != '0) begin
                        left_d  = left_q - 4'd1;
                        shift_d = shift_nx;
                        frame_d = {1'b1, lead_byte(shift_nx)};
                        tx_d    = 1'b0;
                        bit_d   = '0;
                    end else begin
                        state_d = RECV;
                        tx_d    = 1'b1;
                        sil_d   = '0;
                        cnt_d   = '0;
                        asm_d   = '0;
                    end
                end
            end
            RECV: begin
                sil_d = rx_start ? '0 : sil_q + SW'(1);
                if (rx_valid) begin
                    asm_d = asm_nx;
                    if (cnt_q == 4'(DATA_BYTES - 1)) begin
                        state_d = DONE;
                        data_d  = asm_nx;
                        dv_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (rx_err) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                    asm_d   = '0;
                    cnt_d   = '0;
                end else if (!rx_start && sil_q == SW'(TIMEOUT_CLKS - 1)) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    asm_d   = '0;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            frame_q <= '0;
            tmr_q   <= '0;
            bit_q   <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            sil_q   <= '0;
            tx_q    <= 1'b1;
            dv_q    <= 1'b0;
            to_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            sil_q   <= sil_d;
            tx_q    <= tx_d;
            dv_q    <= dv_d;
            to_q    <= to_d;
            fe_q    <= fe_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign data_valid = dv_q;
    assign timeout    = to_q;
    assign frame_err  = fe_q;
endmodule

// File: tb/tb_uart_word_query.sv
// Directed + randomized bench: LSB-first and MSB-first instances driven with identical stimulus.
module tb_uart_word_query;
    localparam int P  = 4;
    localparam int TO = 200;
    // rx fall to timeout pulse: 2 sync flops + edge-detect register, then TO counted cycles
    localparam int TO_LAT = TO + 3;

    logic        clk = 1'b0;
    logic        reset, start, rx;
    logic [15:0] addr;
    logic        tx_w [2];
    logic        busy_w [2];
    logic        dv_w [2];
    logic        to_w [2];
    logic        fe_w [2];
    logic [31:0] data_w [2];

    uart_word_query #(.CLKS_PER_BIT(P), .ADDR_BYTES(2), .DATA_BYTES(4), .MSB_FIRST(0),
                      .TIMEOUT_CLKS(TO)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rx(rx), .tx(tx_w[0]),
        .busy(busy_w[0]), .data(data_w[0]), .data_valid(dv_w[0]), .timeout(to_w[0]),
        .frame_err(fe_w[0]));

    uart_word_query #(.CLKS_PER_BIT(P), .ADDR_BYTES(2), .DATA_BYTES(4), .MSB_FIRST(1),
                      .TIMEOUT_CLKS(TO)) dut_msb (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rx(rx), .tx(tx_w[1]),
        .busy(busy_w[1]), .data(data_w[1]), .data_valid(dv_w[1]), .timeout(to_w[1]),
        .frame_err(fe_w[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0, failures = 0;
    int fall_cyc = 0;
    int dv_cnt [2] = '{0, 0};
    int to_cnt [2] = '{0, 0};
    int fe_cnt [2] = '{0, 0};
    int excl [2]   = '{0, 0};
    int dv_cyc [2] = '{-10, -10};
    int to_cyc [2] = '{0, 0};
    logic [31:0] dv_data [2];
    logic        dv_busy [2];
    logic        post_busy [2];
    logic [7:0]  resp [4];

    // Event monitor: records pulses and their context, no checking here.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cyc == dv_cyc[k] + 1) post_busy[k] = busy_w[k];
            if (dv_w[k]) begin
                dv_cnt[k]++;
                dv_data[k] = data_w[k];
                dv_busy[k] = busy_w[k];
                dv_cyc[k]  = cyc;
            end
            if (to_w[k]) begin
                to_cnt[k]++;
                to_cyc[k] = cyc;
            end
            if (fe_w[k]) fe_cnt[k]++;
            if (int'(dv_w[k]) + int'(to_w[k]) + int'(fe_w[k]) > 1) excl[k]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == 0) fall_cyc = cyc;
            tick(P);
        end
        rx = 1'b1;
    endtask

    function automatic logic [79:0] exp_tx(input logic [15:0] a, input bit msb);
        logic [7:0]  b0, b1;
        logic [19:0] bits;
        logic [79:0] v;
        b0   = msb ? a[15:8] : a[7:0];
        b1   = msb ? a[7:0]  : a[15:8];
        bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        for (int c = 0; c < 80; c++) v[c] = bits[c / P];
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] r [4], input bit msb);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = w | (32'(r[i]) << (8 * (msb ? (3 - i) : i)));
        return w;
    endfunction

    task automatic issue(input logic [15:0] a, input bit poke);
        logic [79:0] o0, o1;
        addr  = a;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            o0[c] = tx_w[0];
            o1[c] = tx_w[1];
            if (poke && c == 30) begin
                start = 1'b1;
                addr  = ~a;
            end else begin
                start = 1'b0;
            end
        end
        check("tx_lsb_frames", o0, exp_tx(a, 1'b0));
        check("tx_msb_frames", o1, exp_tx(a, 1'b1));
        @(negedge clk);
        check("busy_in_recv", {busy_w[0], busy_w[1], tx_w[0], tx_w[1]}, 4'hF);
        tick(1);
    endtask

    task automatic good_query(input logic [15:0] a, input logic [7:0] r [4], input string tag);
        int b0, b1;
        b0 = dv_cnt[0];
        b1 = dv_cnt[1];
        issue(a, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(r[i], 1'b1);
        tick(P);
        check({tag, "_dv_count"}, {dv_cnt[0] - b0, dv_cnt[1] - b1}, {32'd1, 32'd1});
        check({tag, "_data_at_dv"}, {dv_data[0], dv_data[1]}, {exp_word(r, 1'b0), exp_word(r, 1'b1)});
        check({tag, "_data_held"}, {data_w[0], data_w[1]}, {exp_word(r, 1'b0), exp_word(r, 1'b1)});
        check({tag, "_busy_dv_then_low"}, {dv_busy[0], dv_busy[1], post_busy[0], post_busy[1]}, 4'b1100);
    endtask

    initial begin
        logic [31:0] prev0, prev1;
        int          b0, b1, d0, d1;
        logic [15:0] a;

        reset = 1'b1;
        start = 1'b0;
        rx    = 1'b1;
        addr  = '0;
        tick(3);
        check("reset_ctrl", {tx_w[0], tx_w[1], busy_w[0], busy_w[1], dv_w[0], dv_w[1],
                             to_w[0], to_w[1], fe_w[0], fe_w[1]}, 10'b1100000000);
        check("reset_data", {data_w[0], data_w[1]}, 64'd0);
        reset = 1'b0;
        tick(3 * P);

        resp = '{8'h78, 8'h56, 8'h34, 8'h12};
        good_query(16'hA55A, resp, "directed");
        check("directed_words", {data_w[0], data_w[1]}, {32'h12345678, 32'h78563412});

        for (int q = 0; q < 3; q++) begin
            for (int i = 0; i < 4; i++) resp[i] = 8'($urandom);
            good_query(16'($urandom), resp, "random");
        end

        // Silence after two response bytes.
        prev0 = data_w[0];
        prev1 = data_w[1];
        b0 = to_cnt[0]; b1 = to_cnt[1];
        d0 = dv_cnt[0]; d1 = dv_cnt[1];
        issue(16'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        for (int n = 0; n < TO + 50 && !(to_cnt[0] > b0 && to_cnt[1] > b1); n++) tick(1);
        tick(2);
        check("timeout_count", {to_cnt[0] - b0, to_cnt[1] - b1}, {32'd1, 32'd1});
        check("timeout_latency", {to_cyc[0] - fall_cyc, to_cyc[1] - fall_cyc}, {32'(TO_LAT), 32'(TO_LAT)});
        check("timeout_data_kept", {data_w[0], data_w[1]}, {prev0, prev1});
        check("timeout_no_dv", {dv_cnt[0] - d0, dv_cnt[1] - d1, 30'd0, busy_w[0], busy_w[1]}, 96'd0);

        // Bad stop bit on the third byte, plus a start pulse during SEND.
        b0 = fe_cnt[0]; b1 = fe_cnt[1];
        issue(16'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        tick(P);
        check("frame_err_count", {fe_cnt[0] - b0, fe_cnt[1] - b1}, {32'd1, 32'd1});
        check("frame_err_data_kept", {data_w[0], data_w[1]}, {prev0, prev1});
        check("frame_err_idle", {dv_cnt[0] - d0, dv_cnt[1] - d1, 30'd0, busy_w[0], busy_w[1]}, 96'd0);

        // A frame arriving while idle must not produce anything.
        send_byte(8'($urandom), 1'b1);
        tick(P);
        check("idle_frame_ignored", {dv_cnt[0] - d0, dv_cnt[1] - d1, 30'd0, busy_w[0], busy_w[1]}, 96'd0);

        // Reset mid-SEND.
        a     = 16'($urandom);
        addr  = a;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        reset = 1'b1;
        #1;
        check("reset_mid_send", {tx_w[0], tx_w[1], busy_w[0], busy_w[1]}, 4'b1100);
        check("reset_mid_send_data", {data_w[0], data_w[1]}, 64'd0);
        tick(2);
        reset = 1'b0;
        tick(3 * P);
        for (int i = 0; i < 4; i++) resp[i] = 8'($urandom);
        good_query(16'($urandom), resp, "after_reset");

        check("pulse_exclusive", {excl[0], excl[1]}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
